// File: rtl/pentary_matvec_engine.sv
// pentary_matvec_engine
// ---------------------------------------------------------------------------
// Sequential pentary matrix-vector engine. Holds a ROWS x COLS array of
// pentary weight codes, accepts one input vector per valid/ready handshake,
// multiply-accumulates one column per cycle per row with a saturating
// accumulator, and streams each row's requantised pentary digit out through
// a second valid/ready handshake.
//
// Pentary code: 0..4 means value -2..+2 (value = code - 2); codes 5..7 are
// invalid. Invalid codes contribute 0 to the MAC and raise code_err.
//
// Parameters:
//   ROWS   weight rows / output digits per vector
//   COLS   weight columns / input digits per vector
//   ACC_W  signed accumulator width (>= 4)
//   SHIFT  requantisation right shift (0..ACC_W-2), round-half-up
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   w_we/w_row/w_col/w_data  weight write port (accepted only when idle)
//   wr_drop           pulse: weight write ignored because engine busy
//   in_valid/in_ready/in_vec  input vector handshake, digit j at [3j+:3]
//   out_valid/out_ready       result handshake
//   out_digit         requantised pentary code
//   out_acc           signed accumulator after optional activation
//   out_row/out_last  row index of result / result is the final row
//   busy              engine not idle
//   code_err          pulse: invalid code written or consumed this cycle
//
// Build option:
//   PENTARY_MATVEC_RELU_EN  clamp the accumulator to max(acc,0) before
//                           out_acc and requantisation.
// ---------------------------------------------------------------------------
module pentary_matvec_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int ACC_W = 16,
  parameter int SHIFT = 1,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w_we,
  input  logic [ROW_W-1:0]   w_row,
  input  logic [COL_W-1:0]   w_col,
  input  logic [2:0]         w_data,
  output logic               wr_drop,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*COLS-1:0]  in_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_digit,
  output logic [ACC_W-1:0]   out_acc,
  output logic [ROW_W-1:0]   out_row,
  output logic               out_last,
  output logic               busy,
  output logic               code_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_EMIT
  } state_t;

  localparam logic [ROW_W-1:0]        LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]        LAST_COL = COL_W'(COLS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] P2       = ACC_W'(2);
  localparam logic signed [ACC_W-1:0] N2       = ACC_W'(-2);

  // Signed value of a pentary code; invalid codes read as zero.
  function automatic logic signed [3:0] pent_val(input logic [2:0] code);
    pent_val = (code <= 3'd4) ? $signed({1'b0, code} - 4'd2) : 4'sd0;
  endfunction

  function automatic logic pent_bad(input logic [2:0] code);
    pent_bad = (code > 3'd4);
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [2:0]              r_w [ROWS][COLS];
  logic [2:0]              r_x [COLS];
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic signed [ACC_W-1:0] r_acc;

  logic [2:0]              r_out_digit;
  logic [ACC_W-1:0]        r_out_acc;
  logic [ROW_W-1:0]        r_out_row;
  logic                    r_out_last;

  logic [2:0]              w_wcode;
  logic [2:0]              w_xcode;
  logic signed [3:0]       w_prod;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_act;
  logic signed [ACC_W-1:0] w_t;
  logic [2:0]              w_digit;
  logic                    w_addr_ok;

  // ---------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------
  assign w_wcode = r_w[r_row][r_col];
  assign w_xcode = r_x[r_col];

  // Product magnitude is at most 4, so a 4-bit signed product is exact.
  assign w_prod = pent_val(w_wcode) * pent_val(w_xcode);

  // One guard bit detects overflow of the running sum.
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-3){w_prod[3]}}, w_prod};

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_acc_nxt = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

`ifdef PENTARY_MATVEC_RELU_EN
  assign w_act = w_acc_nxt[ACC_W-1] ? '0 : w_acc_nxt;
`else
  assign w_act = w_acc_nxt;
`endif

  // ---------------------------------------------------------------------
  // Requantisation: round-half-up shift, rounding add saturates high
  // ---------------------------------------------------------------------
  generate
    if (SHIFT == 0) begin : g_noshift
      assign w_t = w_act;
    end else begin : g_shift
      localparam logic [ACC_W:0] RND = (ACC_W+1)'(1) << (SHIFT - 1);
      logic signed [ACC_W:0]   w_rnd;
      logic signed [ACC_W-1:0] w_rsat;
      assign w_rnd  = {w_act[ACC_W-1], w_act} + RND;
      assign w_rsat = (w_rnd[ACC_W] != w_rnd[ACC_W-1]) ? ACC_MAX : w_rnd[ACC_W-1:0];
      assign w_t    = w_rsat >>> SHIFT;
    end
  endgenerate

  always_comb begin
    w_digit = w_t[2:0] + 3'd2;
    if (w_t > P2) begin
      w_digit = 3'd4;
    end else if (w_t < N2) begin
      w_digit = 3'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_MAC;
      S_MAC:  if (r_col == LAST_COL) w_state_nxt = S_EMIT;
      S_EMIT: if (out_ready) w_state_nxt = (r_row == LAST_ROW) ? S_IDLE : S_MAC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Weight store, vector latch, counters and result registers
  // ---------------------------------------------------------------------
  assign w_addr_ok = (int'(w_row) < ROWS) && (int'(w_col) < COLS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        for (int unsigned j = 0; j < COLS; j++) begin
          r_w[i][j] <= 3'd2;
        end
      end
      for (int unsigned j = 0; j < COLS; j++) begin
        r_x[j] <= 3'd2;
      end
      r_row       <= '0;
      r_col       <= '0;
      r_acc       <= '0;
      r_out_digit <= 3'd2;
      r_out_acc   <= '0;
      r_out_row   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // The write commits on the same edge as the handshake, so a
          // simultaneous write is already visible to the first MAC cycle.
          if (w_we && w_addr_ok) begin
            r_w[w_row][w_col] <= pent_bad(w_data) ? 3'd2 : w_data;
          end
          if (in_valid) begin
            for (int unsigned j = 0; j < COLS; j++) begin
              r_x[j] <= in_vec[3*j +: 3];
            end
            r_row <= '0;
            r_col <= '0;
            r_acc <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_nxt;
          if (r_col == LAST_COL) begin
            r_col       <= '0;
            r_out_acc   <= w_act;
            r_out_digit <= w_digit;
            r_out_row   <= r_row;
            r_out_last  <= (r_row == LAST_ROW);
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready && (r_row != LAST_ROW)) begin
            r_row <= r_row + 1'b1;
            r_col <= '0;
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign out_digit = r_out_digit;
  assign out_acc   = r_out_acc;
  assign out_row   = r_out_row;
  assign out_last  = r_out_last;
  assign wr_drop   = w_we && (r_state != S_IDLE);
  assign code_err  = ((r_state == S_IDLE) && w_we && pent_bad(w_data)) ||
                     ((r_state == S_MAC) && (pent_bad(w_wcode) || pent_bad(w_xcode)));

endmodule

// File: tb/tb_pentary_matvec_engine.sv
// tb_pentary_matvec_engine
// Two engines share every input: A (4x4, ACC_W=16, SHIFT=1) and
// B (4x4, ACC_W=4, SHIFT=0, saturates readily). Results are compared with
// an arithmetic model of the weight array and the requantisation rules.
module tb_pentary_matvec_engine;
  localparam int R    = 4;
  localparam int C    = 4;
  localparam int AW_A = 16;
  localparam int SH_A = 1;
  localparam int AW_B = 4;
  localparam int SH_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        w_we;
  logic [1:0]  w_row;
  logic [1:0]  w_col;
  logic [2:0]  w_data;
  logic        in_valid;
  logic [11:0] in_vec;
  logic        out_ready;

  logic        a_wr_drop, a_in_ready, a_out_valid, a_out_last, a_busy, a_code_err;
  logic [2:0]  a_out_digit;
  logic [15:0] a_out_acc;
  logic [1:0]  a_out_row;
  logic        b_wr_drop, b_in_ready, b_out_valid, b_out_last, b_busy, b_code_err;
  logic [2:0]  b_out_digit;
  logic [3:0]  b_out_acc;
  logic [1:0]  b_out_row;

  pentary_matvec_engine #(.ROWS(R), .COLS(C), .ACC_W(AW_A), .SHIFT(SH_A)) u_a (
    .clk(clk), .reset(reset), .w_we(w_we), .w_row(w_row), .w_col(w_col),
    .w_data(w_data), .wr_drop(a_wr_drop), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_vec(in_vec), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_digit(a_out_digit), .out_acc(a_out_acc),
    .out_row(a_out_row), .out_last(a_out_last), .busy(a_busy),
    .code_err(a_code_err)
  );

  pentary_matvec_engine #(.ROWS(R), .COLS(C), .ACC_W(AW_B), .SHIFT(SH_B)) u_b (
    .clk(clk), .reset(reset), .w_we(w_we), .w_row(w_row), .w_col(w_col),
    .w_data(w_data), .wr_drop(b_wr_drop), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_vec(in_vec), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_digit(b_out_digit), .out_acc(b_out_acc),
    .out_row(b_out_row), .out_last(b_out_last), .busy(b_busy),
    .code_err(b_code_err)
  );

  int checks   = 0;
  int failures = 0;
  int wm [R][C];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pval(input int code);
    return (code <= 4) ? code - 2 : 0;
  endfunction

  // Row dot product with per-step saturation, optional ReLU, rounding shift.
  function automatic void model(input int r, input logic [11:0] v, input int aw,
                                input int sh, output int acc, output int dig);
    int hi, lo, a, s, t;
    hi = (1 << (aw - 1)) - 1;
    lo = -(1 << (aw - 1));
    a  = 0;
    for (int c = 0; c < C; c++) begin
      a = a + pval(wm[r][c]) * pval(int'(v[3*c +: 3]));
      if (a > hi) a = hi;
      if (a < lo) a = lo;
    end
`ifdef PENTARY_MATVEC_RELU_EN
    if (a < 0) a = 0;
`endif
    if (sh == 0) begin
      t = a;
    end else begin
      s = a + (1 << (sh - 1));
      if (s > hi) s = hi;
      t = s >>> sh;
    end
    if (t > 2) t = 2;
    if (t < -2) t = -2;
    acc = a;
    dig = t + 2;
  endfunction

  task automatic reset_chk();
    chk("rst_in_ready", 32'(a_in_ready), 32'(1));
    chk("rst_out_valid", 32'(a_out_valid), 32'(0));
    chk("rst_digit_a", 32'(a_out_digit), 32'(2));
    chk("rst_digit_b", 32'(b_out_digit), 32'(2));
    chk("rst_acc_a", 32'(a_out_acc), 32'(0));
    chk("rst_acc_b", 32'(b_out_acc), 32'(0));
    chk("rst_row", 32'(a_out_row), 32'(0));
    chk("rst_last", 32'(a_out_last), 32'(0));
    chk("rst_busy", 32'(a_busy), 32'(0));
    chk("rst_wr_drop", 32'(a_wr_drop), 32'(0));
    chk("rst_code_err", 32'(a_code_err), 32'(0));
  endtask

  task automatic write_w(input int r, input int c, input int code);
    w_we   = 1'b1;
    w_row  = 2'(r);
    w_col  = 2'(c);
    w_data = 3'(code);
    #1;
    chk("wr_err_a", 32'(a_code_err), 32'(code > 4));
    chk("wr_err_b", 32'(b_code_err), 32'(code > 4));
    chk("wr_nodrop", 32'(a_wr_drop), 32'(0));
    tick();
    w_we = 1'b0;
    wm[r][c] = (code > 4) ? 2 : code;
  endtask

  task automatic emit_chk(input int r, input int ea, input int eda, input int eb, input int edb);
    logic [15:0] xa;
    logic [3:0]  xb;
    xa = 16'(ea);
    xb = 4'(eb);
    chk("emit_valid_a", 32'(a_out_valid), 32'(1));
    chk("emit_valid_b", 32'(b_out_valid), 32'(1));
    chk("emit_acc_a", 32'(a_out_acc), 32'(xa));
    chk("emit_acc_b", 32'(b_out_acc), 32'(xb));
    chk("emit_digit_a", 32'(a_out_digit), 32'(eda));
    chk("emit_digit_b", 32'(b_out_digit), 32'(edb));
    chk("emit_row", 32'(a_out_row), 32'(r));
    chk("emit_last", 32'(a_out_last), 32'(r == R - 1));
    chk("emit_code_err", 32'(a_code_err), 32'(0));
  endtask

  // Runs one vector from an idle engine. hold_row >= R means no stall.
  task automatic run_vec(input logic [11:0] v, input int hold_row, input int hold_n,
                         input bit same_wr, input int wr_r, input int wr_c, input int wr_code);
    int ea [R];
    int eda[R];
    int eb [R];
    int edb[R];
    int busy_cnt, hold_eff, hr, hc;
    chk("start_in_ready_a", 32'(a_in_ready), 32'(1));
    chk("start_in_ready_b", 32'(b_in_ready), 32'(1));
    if (same_wr) begin
      w_we   = 1'b1;
      w_row  = 2'(wr_r);
      w_col  = 2'(wr_c);
      w_data = 3'(wr_code);
    end
    in_valid = 1'b1;
    in_vec   = v;
    #1;
    if (same_wr) chk("same_wr_err", 32'(a_code_err), 32'(wr_code > 4));
    tick();
    if (same_wr) wm[wr_r][wr_c] = (wr_code > 4) ? 2 : wr_code;
    w_we     = 1'b0;
    in_valid = 1'b0;
    in_vec   = 12'($urandom);
    for (int r = 0; r < R; r++) begin
      model(r, v, AW_A, SH_A, ea[r], eda[r]);
      model(r, v, AW_B, SH_B, eb[r], edb[r]);
    end
    hold_eff = (hold_row < R) ? hold_n : 0;
    busy_cnt = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        chk("mac_valid", 32'(a_out_valid), 32'(0));
        chk("mac_err_a", 32'(a_code_err), 32'((wm[r][c] > 4) || (v[3*c +: 3] > 3'd4)));
        chk("mac_err_b", 32'(b_code_err), 32'((wm[r][c] > 4) || (v[3*c +: 3] > 3'd4)));
        busy_cnt += int'(a_busy);
        tick();
      end
      emit_chk(r, ea[r], eda[r], eb[r], edb[r]);
      busy_cnt += int'(a_busy);
      if (r == hold_row && hold_n > 0) begin
        out_ready = 1'b0;
        for (int k = 0; k < hold_n; k++) begin
          if (k == 0) begin
            hr     = int'($urandom_range(0, R - 1));
            hc     = int'($urandom_range(0, C - 1));
            w_we   = 1'b1;
            w_row  = 2'(hr);
            w_col  = 2'(hc);
            w_data = 3'((wm[hr][hc] + 1) % 5);
            #1;
            chk("hold_wr_drop_a", 32'(a_wr_drop), 32'(1));
            chk("hold_wr_drop_b", 32'(b_wr_drop), 32'(1));
          end
          tick();
          w_we = 1'b0;
          emit_chk(r, ea[r], eda[r], eb[r], edb[r]);
          busy_cnt += int'(a_busy);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk("end_in_ready", 32'(a_in_ready), 32'(1));
    chk("end_busy", 32'(a_busy), 32'(0));
    chk("busy_cycles", 32'(busy_cnt), 32'(R * (C + 1) + hold_eff));
  endtask

  initial begin
    logic [11:0] v;
    int hr, hn;
    bit sw;
    reset     = 1'b1;
    w_we      = 1'b0;
    w_row     = '0;
    w_col     = '0;
    w_data    = '0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) wm[i][j] = 2;
    tick();
    tick();
    reset = 1'b0;
    reset_chk();

    // All weights +2, input all +2: A gives 16 / digit 4, B saturates at 7.
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) write_w(i, j, 4);
    run_vec(12'h924, R, 0, 1'b0, 0, 0, 0);

    // Row0 = [+1,0,0,0], input [-2,0,0,0]; stall row 1 for 5 cycles with a write.
    write_w(0, 0, 3);
    write_w(0, 1, 2);
    write_w(0, 2, 2);
    write_w(0, 3, 2);
    run_vec({3'd2, 3'd2, 3'd2, 3'd0}, 1, 5, 1'b0, 0, 0, 0);

    // Invalid weight write, then an input digit with code 7.
    write_w(1, 1, 6);
    run_vec({3'd3, 3'd7, 3'd4, 3'd1}, R, 0, 1'b0, 0, 0, 0);

    // Weight write in the same cycle as the input handshake.
    run_vec(12'h924, R, 0, 1'b1, 2, 3, 0);

    // Randomised vectors, writes and stalls.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 4; k++)
        write_w(int'($urandom_range(0, R - 1)), int'($urandom_range(0, C - 1)),
                int'($urandom_range(0, 7)));
      for (int j = 0; j < C; j++)
        v[3*j +: 3] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                 : 3'($urandom_range(0, 4));
      hr = int'($urandom_range(0, R));
      hn = int'($urandom_range(1, 3));
      sw = 1'($urandom_range(0, 1));
      run_vec(v, hr, hn, sw, int'($urandom_range(0, R - 1)),
              int'($urandom_range(0, C - 1)), int'($urandom_range(0, 7)));
    end

    // Reset during MAC of row 2 discards the vector and clears the weights.
    in_valid = 1'b1;
    in_vec   = 12'h924;
    tick();
    in_valid = 1'b0;
    repeat (2 * (C + 1) + 2) tick();
    chk("pre_reset_busy", 32'(a_busy), 32'(1));
    chk("pre_reset_valid", 32'(a_out_valid), 32'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_chk();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) wm[i][j] = 2;
    for (int j = 0; j < C; j++) v[3*j +: 3] = 3'($urandom_range(0, 4));
    run_vec(v, R, 0, 1'b0, 0, 0, 0);
    chk("zero_w_digit_a", 32'(a_out_digit), 32'(2));
    chk("zero_w_digit_b", 32'(b_out_digit), 32'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
